// File: rtl/tea_xtea_engine_if.sv
// Block-stream interface of the TEA/XTEA engine.
// Carries the ingress block with its per-block key/mode sideband and the
// egress result.
//
// Handshake: a beat transfers on a rising clock edge where valid and ready
// are both high. A source holds valid and its data/sideband stable until that
// transfer; ready may be driven without waiting for valid.
//
// The "slave" modport is the engine view (consumes ingress, produces egress).
// The "master" modport is the surrounding-system view.
interface tea_xtea_engine_if;
    logic [127:0] i_key;
    logic [1:0]   i_mode;
    logic         i_axis_valid_s;
    logic         o_axis_ready_s;
    logic [63:0]  i_axis_data_s;
    logic         o_axis_valid_m;
    logic         i_axis_ready_m;
    logic [63:0]  o_axis_data_m;

    modport slave (
        input  i_key,
        input  i_mode,
        input  i_axis_valid_s,
        input  i_axis_data_s,
        input  i_axis_ready_m,
        output o_axis_ready_s,
        output o_axis_valid_m,
        output o_axis_data_m
    );

    modport master (
        output i_key,
        output i_mode,
        output i_axis_valid_s,
        output i_axis_data_s,
        output i_axis_ready_m,
        input  o_axis_ready_s,
        input  o_axis_valid_m,
        input  o_axis_data_m
    );
endinterface

// File: rtl/tea_xtea_engine.sv
// Iterative 64-bit TEA/XTEA cipher core, one full round per clock.
// Each block carries its own key and mode; both are captured at accept time.
// Every block spends exactly NUM_ROUNDS cycles in PROCESSING.
module tea_xtea_engine #(
    parameter int unsigned NUM_ROUNDS  = 32,
    parameter logic [31:0] DELTA       = 32'h9E3779B9,
    parameter bit          ENABLE_XTEA = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    tea_xtea_engine_if.slave  bus,
    output logic              o_busy,
    output logic [5:0]        o_round,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_LOADING    = 2'b01,
        ST_PROCESSING = 2'b10,
        ST_DONE       = 2'b11
    } state_t;

    // Starting sum for decryption is the sum reached after a full encryption.
    localparam logic [63:0] SUM_FULL   = 64'(DELTA) * 64'(NUM_ROUNDS);
    localparam logic [31:0] SUM_DEC    = SUM_FULL[31:0];
    localparam logic [5:0]  LAST_ROUND = 6'(NUM_ROUNDS - 1);

    state_t        state_q, state_d;
    logic [31:0]   v0_q, v0_d;
    logic [31:0]   v1_q, v1_d;
    logic [31:0]   sum_q, sum_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [127:0]  key_q, key_d;
    logic [1:0]    mode_q, mode_d;

    logic [31:0]   r_v0, r_v1, r_sum, sum_mid;

    // k[0]=k0 (MSW) .. k[3]=k3 (LSW)
    function automatic logic [31:0] key_word(input logic [127:0] key, input logic [1:0] idx);
        case (idx)
            2'd0:    return key[127:96];
            2'd1:    return key[95:64];
            2'd2:    return key[63:32];
            default: return key[31:0];
        endcase
    endfunction

    function automatic logic [31:0] tea_f(input logic [31:0] v, input logic [31:0] s,
                                          input logic [31:0] ka, input logic [31:0] kb);
        return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
    endfunction

    function automatic logic [31:0] xtea_f(input logic [31:0] v, input logic [31:0] s,
                                           input logic [127:0] key, input logic [1:0] idx);
        return (((v << 4) ^ (v >> 5)) + v) ^ (s + key_word(key, idx));
    endfunction

    // One complete round for the latched mode; decrypt paths undo encrypt in reverse order.
    always_comb begin
        r_v0    = v0_q;
        r_v1    = v1_q;
        r_sum   = sum_q;
        sum_mid = '0;
        case (mode_q)
            2'b00: begin
                sum_mid = sum_q + DELTA;
                r_v0    = v0_q + tea_f(v1_q, sum_mid, key_q[127:96], key_q[95:64]);
                r_v1    = v1_q + tea_f(r_v0, sum_mid, key_q[63:32], key_q[31:0]);
                r_sum   = sum_mid;
            end
            2'b01: begin
                r_v1    = v1_q - tea_f(v0_q, sum_q, key_q[63:32], key_q[31:0]);
                r_v0    = v0_q - tea_f(r_v1, sum_q, key_q[127:96], key_q[95:64]);
                r_sum   = sum_q - DELTA;
            end
            2'b10: begin
                r_v0    = v0_q + xtea_f(v1_q, sum_q, key_q, sum_q[1:0]);
                sum_mid = sum_q + DELTA;
                r_v1    = v1_q + xtea_f(r_v0, sum_mid, key_q, sum_mid[12:11]);
                r_sum   = sum_mid;
            end
            default: begin
                r_v1    = v1_q - xtea_f(v0_q, sum_q, key_q, sum_q[12:11]);
                sum_mid = sum_q - DELTA;
                r_v0    = v0_q - xtea_f(r_v1, sum_mid, key_q, sum_mid[1:0]);
                r_sum   = sum_mid;
            end
        endcase
    end

    // Next-state and datapath update; key/mode are only sampled on accept.
    always_comb begin
        state_d = state_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_axis_valid_s) begin
                    v0_d    = bus.i_axis_data_s[63:32];
                    v1_d    = bus.i_axis_data_s[31:0];
                    key_d   = bus.i_key;
                    mode_d  = {bus.i_mode[1] & ENABLE_XTEA, bus.i_mode[0]};
                    state_d = ST_LOADING;
                end
            end
            ST_LOADING: begin
                cnt_d   = '0;
                sum_d   = mode_q[0] ? SUM_DEC : 32'd0;
                state_d = ST_PROCESSING;
            end
            ST_PROCESSING: begin
                v0_d  = r_v0;
                v1_d  = r_v1;
                sum_d = r_sum;
                if (cnt_q == LAST_ROUND) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: begin
                if (bus.i_axis_ready_m) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight block.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            v0_q    <= '0;
            v1_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
        end
    end

    // Single-block occupancy: ingress only opens in IDLE, so accept and
    // result handshake can never share a cycle.
    assign bus.o_axis_ready_s = (state_q == ST_IDLE);
    assign bus.o_axis_valid_m = (state_q == ST_DONE);
    assign bus.o_axis_data_m  = (state_q == ST_DONE) ? {v0_q, v1_q} : 64'd0;
    assign o_busy             = (state_q != ST_IDLE);
    assign o_round            = (state_q == ST_PROCESSING) ? cnt_q : 6'd0;
    assign o_state            = state_q;

endmodule

// File: tb/tb_tea_xtea_engine.sv
// Bench for tea_xtea_engine: a 32-round full instance and an 8-round
// TEA-only instance, checked against a block-level reference cipher.
module tb_tea_xtea_engine;

    localparam int          NR_A  = 32;
    localparam int          NR_B  = 8;
    localparam logic [31:0] DELTA = 32'h9E3779B9;

    logic        clk;
    logic        rst_n;
    logic        a_busy, b_busy;
    logic [5:0]  a_round, b_round;
    logic [1:0]  a_state, b_state;
    int          n_checks;
    int          n_fail;
    logic [63:0] exp_q[$];

    tea_xtea_engine_if bus_a();
    tea_xtea_engine_if bus_b();

    tea_xtea_engine #(.NUM_ROUNDS(NR_A), .DELTA(DELTA), .ENABLE_XTEA(1'b1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a),
        .o_busy(a_busy), .o_round(a_round), .o_state(a_state)
    );

    tea_xtea_engine #(.NUM_ROUNDS(NR_B), .DELTA(DELTA), .ENABLE_XTEA(1'b0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b),
        .o_busy(b_busy), .o_round(b_round), .o_state(b_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Whole-block reference cipher.
    function automatic logic [63:0] ref_cipher(input logic [63:0] blk, input logic [127:0] key,
                                               input logic [1:0] mode, input int rounds);
        logic [31:0] v0, v1, sum;
        logic [31:0] k [4];
        k[0] = key[127:96]; k[1] = key[95:64]; k[2] = key[63:32]; k[3] = key[31:0];
        v0 = blk[63:32];
        v1 = blk[31:0];
        sum = 32'd0;
        if (mode[0]) begin
            for (int r = 0; r < rounds; r++) sum = sum + DELTA;
        end
        for (int r = 0; r < rounds; r++) begin
            case (mode)
                2'b00: begin
                    sum = sum + DELTA;
                    v0 = v0 + (((v1 << 4) + k[0]) ^ (v1 + sum) ^ ((v1 >> 5) + k[1]));
                    v1 = v1 + (((v0 << 4) + k[2]) ^ (v0 + sum) ^ ((v0 >> 5) + k[3]));
                end
                2'b01: begin
                    v1 = v1 - (((v0 << 4) + k[2]) ^ (v0 + sum) ^ ((v0 >> 5) + k[3]));
                    v0 = v0 - (((v1 << 4) + k[0]) ^ (v1 + sum) ^ ((v1 >> 5) + k[1]));
                    sum = sum - DELTA;
                end
                2'b10: begin
                    v0 = v0 + ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]));
                    sum = sum + DELTA;
                    v1 = v1 + ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]));
                end
                default: begin
                    v1 = v1 - ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]));
                    sum = sum - DELTA;
                    v0 = v0 - ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]));
                end
            endcase
        end
        return {v0, v1};
    endfunction

    // Present one block to instance A and queue its expected result.
    task automatic drive_a(input logic [63:0] data, input logic [127:0] key,
                           input logic [1:0] mode, input logic [63:0] exp);
        @(posedge clk); #1;
        check("a_ready_s_idle", 64'(bus_a.o_axis_ready_s), 64'd1);
        bus_a.i_axis_data_s  = data;
        bus_a.i_key          = key;
        bus_a.i_mode         = mode;
        bus_a.i_axis_valid_s = 1'b1;
        exp_q.push_back(exp);
    endtask

    // Wait for instance A's result, optionally stalling and scrambling inputs.
    task automatic collect_a(input int bp, input bit toggle, input bit chk_rounds);
        int lat;
        logic [63:0] held;
        logic [63:0] exp;
        for (lat = 1; lat <= NR_A + 20; lat++) begin
            @(posedge clk); #1;
            bus_a.i_axis_valid_s = 1'b0;
            if (toggle) begin
                bus_a.i_key         = {$urandom, $urandom, $urandom, $urandom};
                bus_a.i_mode        = 2'($urandom);
                bus_a.i_axis_data_s = {$urandom, $urandom};
            end
            if (lat == 1) check("a_ready_s_busy", 64'(bus_a.o_axis_ready_s), 64'd0);
            if (chk_rounds)
                check("a_round", 64'(a_round), (lat >= 2 && lat <= NR_A + 1) ? 64'(lat - 2) : 64'd0);
            if (bus_a.o_axis_valid_m) break;
        end
        check("a_latency", 64'(lat), 64'(NR_A + 2));
        exp = exp_q.pop_front();
        if (!bus_a.o_axis_valid_m) return;
        held = bus_a.o_axis_data_m;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check("a_bp_valid", 64'(bus_a.o_axis_valid_m), 64'd1);
            check("a_bp_data", bus_a.o_axis_data_m, held);
            check("a_bp_ready_s", 64'(bus_a.o_axis_ready_s), 64'd0);
        end
        check("a_result", held, exp);
        bus_a.i_axis_ready_m = 1'b1;
        @(posedge clk); #1;
        bus_a.i_axis_ready_m = 1'b0;
        check("a_valid_drop", 64'(bus_a.o_axis_valid_m), 64'd0);
        check("a_data_zero_idle", bus_a.o_axis_data_m, 64'd0);
    endtask

    // One block through the 8-round TEA-only instance.
    task automatic run_b(input logic [63:0] data, input logic [127:0] key, input logic [1:0] mode);
        int lat;
        logic [63:0] exp;
        exp = ref_cipher(data, key, {1'b0, mode[0]}, NR_B);
        @(posedge clk); #1;
        bus_b.i_axis_data_s  = data;
        bus_b.i_key          = key;
        bus_b.i_mode         = mode;
        bus_b.i_axis_valid_s = 1'b1;
        for (lat = 1; lat <= NR_B + 20; lat++) begin
            @(posedge clk); #1;
            bus_b.i_axis_valid_s = 1'b0;
            if (bus_b.o_axis_valid_m) break;
        end
        check("b_latency", 64'(lat), 64'(NR_B + 2));
        check("b_result", bus_b.o_axis_data_m, exp);
        bus_b.i_axis_ready_m = 1'b1;
        @(posedge clk); #1;
        bus_b.i_axis_ready_m = 1'b0;
    endtask

    // Main sequence
    initial begin
        logic [63:0]  d, r;
        logic [127:0] k;
        logic [1:0]   m;
        int           seen;
        int           lat;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus_a.i_key = '0; bus_a.i_mode = '0; bus_a.i_axis_valid_s = 1'b0;
        bus_a.i_axis_data_s = '0; bus_a.i_axis_ready_m = 1'b0;
        bus_b.i_key = '0; bus_b.i_mode = '0; bus_b.i_axis_valid_s = 1'b0;
        bus_b.i_axis_data_s = '0; bus_b.i_axis_ready_m = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_s", 64'(bus_a.o_axis_ready_s), 64'd1);
        check("rst_valid_m", 64'(bus_a.o_axis_valid_m), 64'd0);
        check("rst_data_m", bus_a.o_axis_data_m, 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_round", 64'(a_round), 64'd0);
        check("rst_state", 64'(a_state), 64'd0);
        check("rst_b_ready_s", 64'(bus_b.o_axis_ready_s), 64'd1);
        @(negedge clk) rst_n = 1'b1;

        // Known-answer vectors, round counter walk on the decrypt
        drive_a(64'd0, 128'd0, 2'b00, 64'h41EA3A0A_94BAA940);
        collect_a(0, 1'b0, 1'b0);
        drive_a(64'h41EA3A0A_94BAA940, 128'd0, 2'b01, 64'd0);
        collect_a(0, 1'b0, 1'b1);
        drive_a(64'd0, 128'd0, 2'b10, 64'hDEE9D4D8_F7131ED9);
        collect_a(0, 1'b0, 1'b0);
        drive_a(64'hDEE9D4D8_F7131ED9, 128'd0, 2'b11, 64'd0);
        collect_a(0, 1'b0, 1'b0);

        // Backpressure with key/mode/data churn while busy
        d = {$urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        m = 2'($urandom);
        drive_a(d, k, m, ref_cipher(d, k, m, NR_A));
        collect_a(5, 1'b1, 1'b0);

        // Random blocks over all modes
        for (int i = 0; i < 6; i++) begin
            d = {$urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            m = 2'($urandom);
            drive_a(d, k, m, ref_cipher(d, k, m, NR_A));
            collect_a(i % 3, (i % 2) == 1, 1'b0);
        end

        // XTEA round trip back to the original plaintext
        d = {$urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        r = ref_cipher(d, k, 2'b10, NR_A);
        drive_a(d, k, 2'b10, r);
        collect_a(0, 1'b0, 1'b0);
        drive_a(r, k, 2'b11, d);
        collect_a(0, 1'b0, 1'b0);

        // 8-round TEA-only instance; XTEA select must be ignored
        for (int i = 0; i < 6; i++)
            run_b({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 2'b00);
        run_b({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 2'b10);
        run_b({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 2'b11);

        // Reset in the middle of a block
        d = {$urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        drive_a(d, k, 2'b00, 64'd0);
        for (lat = 1; lat <= NR_A + 20; lat++) begin
            @(posedge clk); #1;
            bus_a.i_axis_valid_s = 1'b0;
            if (a_round == 6'd10) break;
        end
        check("rst_mid_reached_round", 64'(a_round), 64'd10);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ready_s", 64'(bus_a.o_axis_ready_s), 64'd1);
        check("rst_mid_valid_m", 64'(bus_a.o_axis_valid_m), 64'd0);
        check("rst_mid_data_m", bus_a.o_axis_data_m, 64'd0);
        check("rst_mid_busy", 64'(a_busy), 64'd0);
        check("rst_mid_round", 64'(a_round), 64'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (NR_A + 5) begin
            @(posedge clk); #1;
            if (bus_a.o_axis_valid_m) seen++;
        end
        check("rst_no_partial_result", 64'(seen), 64'd0);
        d = {$urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        drive_a(d, k, 2'b10, ref_cipher(d, k, 2'b10, NR_A));
        collect_a(0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
